mem_arb: RTL and testbench

- Arbitrates one single-ported unified memory between three requesters: loader/debug port X, pipeline data port D (lw/sw), and instruction-fetch port I.
- Serialises accesses and tolerates variable memory latency through a mrdy handshake.
- Returns one-cycle acks with read data and an error flag, and drives a stall output that holds the pipeline while fetch or data access is outstanding.
- Sits between the core's fetch/memory stages and the memory model.

---
 rtl/mem_arb_if.sv | 38 +++
 rtl/mem_arb.sv | 106 ++++++++++
 tb/tb_mem_arb.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Bus bundle between the three requesters, the arbiter and the unified memory.
// The slave modport is the arbiter view; the master modport is the requester/memory view.
interface mem_arb_if #(
  parameter int DATA_W = 32
);
  // Handshake: a requester raises *_req with stable we/addr/wdata and holds it
  // through its one-cycle *_ack; memory completes an mreq with a one-cycle mrdy.
  logic              x_req, d_req, i_req;
  logic              x_we, d_we;
  logic [DATA_W-1:0] x_addr, d_addr, i_addr;
  logic [DATA_W-1:0] x_wdata, d_wdata;
  logic              x_ack, d_ack, i_ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              stall;
  logic              mreq;
  logic              mwe;
  logic [DATA_W-1:0] maddr;
  logic [DATA_W-1:0] mwdata;
  logic [DATA_W-1:0] mrdata;
  logic              mrdy;

  modport slave (
    input  x_req, d_req, i_req, x_we, d_we,
    input  x_addr, d_addr, i_addr, x_wdata, d_wdata,
    input  mrdata, mrdy,
    output x_ack, d_ack, i_ack, rdata, err, stall,
    output mreq, mwe, maddr, mwdata
  );

  modport master (
    output x_req, d_req, i_req, x_we, d_we,
    output x_addr, d_addr, i_addr, x_wdata, d_wdata,
    output mrdata, mrdy,
    input  x_ack, d_ack, i_ack, rdata, err, stall,
    input  mreq, mwe, maddr, mwdata
  );
endinterface

// File: rtl/mem_arb.sv
// Fixed-priority (X > D > I) arbiter for a single-ported memory with
// variable latency, timeout abort and one-cycle acks.
module mem_arb #(
  parameter int DATA_W = 32,
  parameter int TMO    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_arb_if.slave   bus,
  output logic [1:0] state_o
);
  localparam int CNT_W = $clog2(TMO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_X = 2'd0, OWN_D = 2'd1, OWN_I = 2'd2} owner_t;

  state_t            state_q;
  owner_t            owner_q;
  logic              mreq_q, mwe_q;
  logic [DATA_W-1:0] maddr_q, mwdata_q, rdata_q;
  logic              err_q;
  logic              x_ack_q, d_ack_q, i_ack_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              finish;

  // mrdy takes precedence over a timeout landing in the same cycle.
  assign finish = bus.mrdy | (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_X;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      x_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      i_ack_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      x_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (bus.x_req) begin
            owner_q  <= OWN_X;
            mreq_q   <= 1'b1;
            mwe_q    <= bus.x_we;
            maddr_q  <= bus.x_addr;
            mwdata_q <= bus.x_wdata;
            state_q  <= S_BUSY;
          end else if (bus.d_req) begin
            owner_q  <= OWN_D;
            mreq_q   <= 1'b1;
            mwe_q    <= bus.d_we;
            maddr_q  <= bus.d_addr;
            mwdata_q <= bus.d_wdata;
            state_q  <= S_BUSY;
          end else if (bus.i_req) begin
            owner_q  <= OWN_I;
            mreq_q   <= 1'b1;
            mwe_q    <= 1'b0;
            maddr_q  <= bus.i_addr;
            mwdata_q <= '0;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (finish) begin
            mreq_q  <= 1'b0;
            rdata_q <= (bus.mrdy && !mwe_q) ? bus.mrdata : '0;
            err_q   <= ~bus.mrdy;
            x_ack_q <= (owner_q == OWN_X);
            d_ack_q <= (owner_q == OWN_D);
            i_ack_q <= (owner_q == OWN_I);
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mreq   = mreq_q;
  assign bus.mwe    = mwe_q;
  assign bus.maddr  = maddr_q;
  assign bus.mwdata = mwdata_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;
  assign bus.x_ack  = x_ack_q;
  assign bus.d_ack  = d_ack_q;
  assign bus.i_ack  = i_ack_q;
  assign bus.stall  = (bus.i_req & ~i_ack_q) | (bus.d_req & ~d_ack_q);
  assign state_o    = state_q;
endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: a transaction-level arbitration model schedules grants,
// memory latencies and acks; a separate monitor compares the DUT every cycle.
module tb_mem_arb;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;
  localparam int NEVER  = 32'h7fff_ffff;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  mem_arb_if #(.DATA_W(DATA_W)) bus ();
  mem_arb #(.DATA_W(DATA_W), .TMO(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // ---------------- scoreboard storage ----------------
  typedef struct packed {
    logic [31:0]       cyc;
    logic [1:0]        port;
    logic              err;
    logic [DATA_W-1:0] rd;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    int                start;
    int                stop;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wd;
  } mexp_t;
  mexp_t mexp_q[$];

  int                lat_q[$];
  logic [DATA_W-1:0] dat_q[$];

  // requester state, index 0=X 1=D 2=I
  logic              act[3];
  logic              we_a[3];
  logic [DATA_W-1:0] addr_a[3];
  logic [DATA_W-1:0] wd_a[3];
  int                ack_cyc[3];

  int                cyc, free_at, mrdy_cyc, rst_hold, n_resets;
  logic [DATA_W-1:0] mrdata_plan;
  bit                rand_mode;
  int                n_checks, n_fail;

  task automatic check(input string name, input logic [DATA_W-1:0] actual,
                       input logic [DATA_W-1:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, actual, required);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start(input int p, input logic we, input logic [DATA_W-1:0] addr,
                       input logic [DATA_W-1:0] wd);
    act[p]     = 1'b1;
    we_a[p]    = (p == 2) ? 1'b0 : we;
    addr_a[p]  = addr;
    wd_a[p]    = (p == 2) ? '0 : wd;
    ack_cyc[p] = -1;
  endtask

  task automatic drive_ports();
    for (int p = 0; p < 3; p++) begin
      if (act[p] && ack_cyc[p] >= 0 && cyc > ack_cyc[p]) begin
        act[p]     = 1'b0;
        ack_cyc[p] = -1;
      end
      if (!act[p] && rand_mode && $urandom_range(0, 2) == 0)
        start(p, 1'($urandom_range(0, 1)), $urandom(), $urandom());
    end
    bus.x_req   = act[0];  bus.x_we = we_a[0];  bus.x_addr = addr_a[0];  bus.x_wdata = wd_a[0];
    bus.d_req   = act[1];  bus.d_we = we_a[1];  bus.d_addr = addr_a[1];  bus.d_wdata = wd_a[1];
    bus.i_req   = act[2];  bus.i_addr = addr_a[2];
  endtask

  task automatic drive_mem();
    bus.mrdy   = (cyc == mrdy_cyc);
    bus.mrdata = bus.mrdy ? mrdata_plan : $urandom();
  endtask

  // ---------------- reference model ----------------
  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r < 10) return 1;
    if (r < 15) return $urandom_range(2, 6);
    if (r < 17) return $urandom_range(7, TMO - 1);
    if (r == 17) return TMO;
    return TMO + 1;
  endfunction

  task automatic model_abort();
    exp_q.delete();
    mexp_q.delete();
    mrdy_cyc = -1;
    for (int p = 0; p < 3; p++) ack_cyc[p] = -1;
    free_at = NEVER;
  endtask

  // One access occupies: grant cycle c, memory busy c+1..ack-1, ack, then idle again.
  task automatic model_step();
    int    p, k;
    exp_t  e;
    mexp_t m;
    if (cyc < free_at) return;
    p = act[0] ? 0 : act[1] ? 1 : act[2] ? 2 : -1;
    if (p < 0) return;
    k           = (lat_q.size() != 0) ? lat_q.pop_front() : pick_lat();
    mrdata_plan = (dat_q.size() != 0) ? dat_q.pop_front() : $urandom();
    e.port = 2'(p);
    if (k <= TMO) begin
      mrdy_cyc = cyc + k;
      e.cyc    = 32'(cyc + k + 1);
      e.err    = 1'b0;
      e.rd     = we_a[p] ? '0 : mrdata_plan;
    end else begin
      mrdy_cyc = -1;
      e.cyc    = 32'(cyc + TMO + 1);
      e.err    = 1'b1;
      e.rd     = '0;
    end
    m.start = cyc + 1;
    m.stop  = int'(e.cyc) - 1;
    m.we    = we_a[p];
    m.addr  = addr_a[p];
    m.wd    = wd_a[p];
    mexp_q.push_back(m);
    exp_q.push_back(e);
    ack_cyc[p] = int'(e.cyc);
    free_at    = int'(e.cyc) + 1;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (rst_hold > 0) begin
      if (rst_n) begin
        rst_n = 1'b0;
        model_abort();
      end
      rst_hold--;
    end else if (!rst_n) begin
      rst_n   = 1'b1;
      free_at = cyc;
    end
    drive_ports();
    drive_mem();
    if (rst_n) model_step();
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((act[0] || act[1] || act[2] || exp_q.size() != 0) && n < bound) begin
      step();
      n++;
    end
    check("wait_bound", DATA_W'(n < bound), DATA_W'(1));
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t              e;
    bit                have;
    bit                in_busy;
    logic [2:0]        exp_ack;
    logic [DATA_W-1:0] last_rd;
    logic              last_err;
    last_rd  = '0;
    last_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        last_rd  = '0;
        last_err = 1'b0;
        check("rst_mreq", DATA_W'(bus.mreq), DATA_W'(0));
        check("rst_acks", DATA_W'({bus.x_ack, bus.d_ack, bus.i_ack}), DATA_W'(0));
        check("rst_stall", DATA_W'(bus.stall), DATA_W'(bus.i_req | bus.d_req));
      end else begin
        have = 1'b0;
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          if (int'(e.cyc) == cyc) begin
            e    = exp_q.pop_front();
            have = 1'b1;
          end
        end
        exp_ack = have ? (3'b100 >> e.port) : 3'b000;
        check("ack", DATA_W'({bus.x_ack, bus.d_ack, bus.i_ack}), DATA_W'(exp_ack));
        if (have) begin
          last_rd  = e.rd;
          last_err = e.err;
        end
        check("rdata", bus.rdata, last_rd);
        check("err", DATA_W'(bus.err), DATA_W'(last_err));
        check("stall", DATA_W'(bus.stall),
              DATA_W'((bus.i_req & ~exp_ack[0]) | (bus.d_req & ~exp_ack[1])));
        while (mexp_q.size() != 0 && mexp_q[0].stop < cyc) void'(mexp_q.pop_front());
        in_busy = (mexp_q.size() != 0) && (mexp_q[0].start <= cyc) && (cyc <= mexp_q[0].stop);
        check("mreq", DATA_W'(bus.mreq), DATA_W'(in_busy));
        if (in_busy) begin
          check("maddr", bus.maddr, mexp_q[0].addr);
          check("mwe", DATA_W'(bus.mwe), DATA_W'(mexp_q[0].we));
          check("mwdata", bus.mwdata, mexp_q[0].wd);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;  n_fail = 0;  cyc = 0;  free_at = NEVER;
    mrdy_cyc = -1; rst_hold = 0; n_resets = 0; rand_mode = 1'b0;
    mrdata_plan = '0;
    for (int p = 0; p < 3; p++) begin
      act[p] = 1'b0; we_a[p] = 1'b0; addr_a[p] = '0; wd_a[p] = '0; ack_cyc[p] = -1;
    end
    bus.x_req = 1'b0; bus.d_req = 1'b0; bus.i_req = 1'b0;
    bus.x_we = 1'b0;  bus.d_we = 1'b0;
    bus.x_addr = '0;  bus.d_addr = '0;  bus.i_addr = '0;
    bus.x_wdata = '0; bus.d_wdata = '0;
    bus.mrdy = 1'b0;  bus.mrdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", DATA_W'(state_dbg), DATA_W'(0));
    check("rst_mwe", DATA_W'(bus.mwe), DATA_W'(0));
    check("rst_maddr", bus.maddr, '0);
    check("rst_mwdata", bus.mwdata, '0);
    check("rst_rdata", bus.rdata, '0);
    check("rst_err", DATA_W'(bus.err), DATA_W'(0));

    // single I read, zero-wait memory
    lat_q.push_back(1);
    dat_q.push_back(32'h2008_000A);
    start(2, 1'b0, 32'h40, '0);
    wait_idle(50);
    // D store and I fetch together: D first
    lat_q.push_back(1); lat_q.push_back(1);
    start(1, 1'b1, 32'h80, 32'h5);
    start(2, 1'b0, 32'h44, '0);
    wait_idle(50);
    // all three together: X, D, I
    repeat (3) lat_q.push_back(1);
    start(0, 1'b1, 32'h200, 32'hCAFE_0001);
    start(1, 1'b0, 32'h84, '0);
    start(2, 1'b0, 32'h48, '0);
    wait_idle(50);
    // wait states
    lat_q.push_back(4);
    start(1, 1'b0, 32'h100, '0);
    wait_idle(50);
    // timeout, then a normal access
    lat_q.push_back(TMO + 1); lat_q.push_back(1);
    start(1, 1'b0, 32'h104, '0);
    start(2, 1'b0, 32'h108, '0);
    wait_idle(80);
    // mrdy on the last BUSY cycle beats the timeout
    lat_q.push_back(TMO);
    start(1, 1'b0, 32'h10C, '0);
    wait_idle(80);
    // reset mid-access, then the pending request is re-granted
    lat_q.push_back(10); lat_q.push_back(1);
    start(1, 1'b0, 32'h110, '0);
    step();
    step();
    rst_hold = 2;
    wait_idle(80);

    // randomized traffic with occasional resets during BUSY
    lat_q.delete();
    dat_q.delete();
    rand_mode = 1'b1;
    repeat (2500) begin
      if (rst_n && rst_hold == 0 && n_resets < 3 && mexp_q.size() != 0 &&
          mexp_q[0].start <= cyc + 1 && cyc + 1 <= mexp_q[0].stop &&
          $urandom_range(0, 99) == 0) begin
        rst_hold = 2;
        n_resets++;
      end
      step();
    end
    rand_mode = 1'b0;
    wait_idle(200);
    step();
    check("exp_q_empty", DATA_W'(exp_q.size()), DATA_W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
